// File: rtl/prienc_pkg.sv
// Shared definitions for the sequential match-vector priority iterator:
// FSM state type, default segment width and an index-width helper.
package prienc_pkg;

  // Default segment width of the two-level encoder.
  localparam int DEF_SEG_W = 8;

  // FSM state constants, also used as the enum encoding.
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_ITER = 1'b1;

  typedef enum logic [0:0] {
    ST_IDLE = S_IDLE,
    ST_ITER = S_ITER
  } state_e;

  // Index width that never collapses to zero for degenerate widths.
  function automatic int idx_w_of(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/prienc_lsb_param.sv
// Combinational LSB-first priority encoder, two-level structure:
// segment OR -> row (lowest non-empty segment) -> column (lowest bit in
// that segment). The selected segment is fetched through a binary mux tree
// that is log2(WIDTH/SEG_W) levels deep.
module prienc_lsb_param
  import prienc_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int SEG_W = DEF_SEG_W,
  parameter int IDX_W = idx_w_of(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  output logic [IDX_W-1:0] lsb_priority,
  output logic             any_hit
);

  localparam int NSEG  = WIDTH / SEG_W;
  localparam int LVLS  = $clog2(NSEG);
  localparam int ROW_W = idx_w_of(NSEG);
  localparam int COL_W = idx_w_of(SEG_W);

  logic [NSEG-1:0]  seg_any;
  logic [ROW_W-1:0] row_idx;
  logic [COL_W-1:0] col_idx;
  logic [SEG_W-1:0] col_seg;
  logic [SEG_W-1:0] lvl [NSEG];

  genvar s;
  for (s = 0; s < NSEG; s++) begin : g_seg
    assign seg_any[s] = |req[s*SEG_W +: SEG_W];
  end

  // Row encode: lowest segment with any bit set.
  always_comb begin
    row_idx = '0;
    for (int r = NSEG - 1; r >= 0; r--) begin
      if (seg_any[r]) row_idx = ROW_W'(r);
    end
  end

  // Segment mux tree: level l pairs neighbouring nodes on row_idx bit l,
  // overwriting in place (node j only reads nodes 2j and 2j+1, which are
  // never already overwritten at that level).
  always_comb begin
    for (int k = 0; k < NSEG; k++) begin
      lvl[k] = req[k*SEG_W +: SEG_W];
    end
    for (int l = 0; l < LVLS; l++) begin
      for (int j = 0; j < (NSEG >> (l + 1)); j++) begin
        lvl[j] = row_idx[l] ? lvl[2*j+1] : lvl[2*j];
      end
    end
    col_seg = lvl[0];
  end

  // Column encode: lowest set bit inside the selected segment.
  always_comb begin
    col_idx = '0;
    for (int c = SEG_W - 1; c >= 0; c--) begin
      if (col_seg[c]) col_idx = COL_W'(c);
    end
  end

  assign any_hit      = |seg_any;
  assign lsb_priority = IDX_W'(int'(row_idx) * SEG_W + int'(col_idx));

endmodule

// File: rtl/prienc_match_iter.sv
// Sequential CAM multi-hit iterator: registers a match vector and emits the
// index of every set bit in ascending order, one per output handshake.
// An all-zero vector produces a single "none" beat with index 0.
// Optional build macro: PRIENC_MATCH_COUNT_EN adds match_cnt, the popcount
// of the accepted vector, held for the whole iteration.
module prienc_match_iter
  import prienc_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int SEG_W = DEF_SEG_W,
  parameter int IDX_W = idx_w_of(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_vec,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_none
`ifdef PRIENC_MATCH_COUNT_EN
  ,
  output logic [IDX_W:0]   match_cnt
`endif
);

  state_e           state_p0;
  logic [WIDTH-1:0] rem_p0;
  logic             none_p0;

  logic [IDX_W-1:0] enc_idx;
  logic             enc_any;
  logic [WIDTH-1:0] rem_next;
  logic             out_fire;
  logic             accept;

  prienc_lsb_param #(
    .WIDTH (WIDTH),
    .SEG_W (SEG_W),
    .IDX_W (IDX_W)
  ) u_enc (
    .req          (rem_p0),
    .lsb_priority (enc_idx),
    .any_hit      (enc_any)
  );

  // Remaining vector with its lowest set bit cleared.
  assign rem_next  = rem_p0 & (rem_p0 - WIDTH'(1));

  // Outputs depend on registers only; nothing from req_* reaches out_*.
  assign out_valid = (state_p0 == ST_ITER);
  assign out_none  = out_valid && none_p0;
  assign out_idx   = (out_valid && !none_p0) ? enc_idx : '0;
  assign out_last  = out_valid && (none_p0 || (enc_any && (rem_next == '0)));

  assign out_fire  = out_valid && out_ready;
  // Ready during the final beat lets the next vector follow with no bubble;
  // flush blocks any accept in its cycle.
  assign req_ready = !flush && ((state_p0 == ST_IDLE) || (out_fire && out_last));
  assign accept    = req_valid && req_ready;

  // FSM and remaining-vector register: reset/flush, accept, then consume.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0 <= ST_IDLE;
      rem_p0   <= '0;
      none_p0  <= 1'b0;
    end else if (flush) begin
      state_p0 <= ST_IDLE;
      rem_p0   <= '0;
      none_p0  <= 1'b0;
    end else if (accept) begin
      state_p0 <= ST_ITER;
      rem_p0   <= req_vec;
      none_p0  <= (req_vec == '0);
    end else if (out_fire) begin
      rem_p0 <= rem_next;
      if (out_last) begin
        state_p0 <= ST_IDLE;
        none_p0  <= 1'b0;
      end
    end
  end

`ifdef PRIENC_MATCH_COUNT_EN
  function automatic logic [IDX_W:0] popcount(input logic [WIDTH-1:0] v);
    logic [IDX_W:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      c = c + (IDX_W + 1)'(v[i]);
    end
    return c;
  endfunction

  // Hit count captured on accept and held until the next accept or reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      match_cnt <= '0;
    end else if (accept) begin
      match_cnt <= popcount(req_vec);
    end
  end
`endif

endmodule

// File: tb/tb_prienc_match_iter.sv
// Scoreboard bench for prienc_match_iter: the driver pushes the expected
// beat list of each accepted vector, a negedge monitor pops on handshakes.
module tb_prienc_match_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_vec;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_idx;
  logic        out_last;
  logic        out_none;
`ifdef PRIENC_MATCH_COUNT_EN
  logic [6:0]  match_cnt;
  logic [7:0]  match_cnt2;
`endif

  logic         req_valid2;
  logic         req_ready2;
  logic [127:0] req_vec2;
  logic         out_valid2;
  logic         out_ready2;
  logic [6:0]   out_idx2;
  logic         out_last2;
  logic         out_none2;

  always #5 clk = ~clk;

  prienc_match_iter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_vec   (req_vec),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_none  (out_none)
`ifdef PRIENC_MATCH_COUNT_EN
    ,
    .match_cnt (match_cnt)
`endif
  );

  prienc_match_iter #(.WIDTH(128), .SEG_W(16)) dut128 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid2),
    .req_ready (req_ready2),
    .req_vec   (req_vec2),
    .flush     (1'b0),
    .out_valid (out_valid2),
    .out_ready (out_ready2),
    .out_idx   (out_idx2),
    .out_last  (out_last2),
    .out_none  (out_none2)
`ifdef PRIENC_MATCH_COUNT_EN
    ,
    .match_cnt (match_cnt2)
`endif
  );

  typedef struct {
    int idx;
    bit last;
    bit none;
    int cnt;
  } beat_t;

  beat_t q[$];
  int    n_vec = 0;
  int    n_err = 0;
  bit    rand_ready = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: ascending list of hit indices, last flag on the final
  // one; an empty vector gives a single none-beat.
  task automatic push_expect(input logic [63:0] v);
    int hits[$];
    for (int i = 0; i < 64; i++) if (v[i]) hits.push_back(i);
    if (hits.size() == 0) begin
      q.push_back('{idx: 0, last: 1'b1, none: 1'b1, cnt: 0});
    end else begin
      foreach (hits[k]) begin
        q.push_back('{idx: hits[k], last: (k == hits.size() - 1), none: 1'b0, cnt: hits.size()});
      end
    end
  endtask

  // Offer one vector (called at posedge+2); returns at posedge+2 after accept.
  task automatic send(input logic [63:0] v);
    bit done;
    done = 1'b0;
    req_vec   = v;
    req_valid = 1'b1;
    for (int t = 0; t < 1000 && !done; t++) begin
      @(negedge clk);
      if (req_ready) done = 1'b1;
    end
    @(posedge clk);
    if (done) push_expect(v);
    else chk("accept_timeout", 128'(0), 128'(1));
    #2;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 2000 && !done; t++) begin
      @(posedge clk);
      if (q.size() == 0) done = 1'b1;
    end
    if (!done) chk("drain_timeout", 128'(q.size()), 128'(0));
    #2;
  endtask

  task automatic wait_q_le(input int n);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 200 && !done; t++) begin
      @(posedge clk);
      if (q.size() <= n) done = 1'b1;
    end
    if (!done) chk("progress_timeout", 128'(q.size()), 128'(n));
    #2;
  endtask

  // Consumer back-pressure.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: handshake/ready/valid checks against the scoreboard queue.
  initial begin
    bit         stall_prev;
    logic [5:0] idx_prev;
    beat_t      b;
    stall_prev = 1'b0;
    idx_prev   = '0;
    forever begin
      @(negedge clk);
      if (!rst && !flush) begin
        chk("out_valid", 128'(out_valid), 128'(q.size() != 0));
        chk("req_ready", 128'(req_ready), 128'((q.size() == 0) || (q.size() == 1 && out_ready)));
        if (stall_prev && out_valid) chk("stall_idx", 128'(out_idx), 128'(idx_prev));
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_beat", 128'(out_idx), 128'(0));
          end else begin
            b = q.pop_front();
            chk("out_idx", 128'(out_idx), 128'(b.idx));
            chk("out_last", 128'(out_last), 128'(b.last));
            chk("out_none", 128'(out_none), 128'(b.none));
`ifdef PRIENC_MATCH_COUNT_EN
            chk("match_cnt", 128'(match_cnt), 128'(b.cnt));
`endif
          end
        end
      end
      stall_prev = !rst && !flush && out_valid && !out_ready;
      idx_prev   = out_idx;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0]  v;
    logic [127:0] w;
    int           bitpos;

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_vec    = '0;
    flush      = 1'b0;
    req_valid2 = 1'b0;
    req_vec2   = '0;
    out_ready2 = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 128'(out_valid), 128'(0));
    chk("rst_idx", 128'(out_idx), 128'(0));
    chk("rst_last", 128'(out_last), 128'(0));
    chk("rst_none", 128'(out_none), 128'(0));
    chk("rst_ready", 128'(req_ready), 128'(1));
`ifdef PRIENC_MATCH_COUNT_EN
    chk("rst_cnt", 128'(match_cnt), 128'(0));
`endif
    @(posedge clk);
    #2;

    // Three scattered hits.
    send(64'h8000_0000_0001_0010);
    wait_idle();

    // All-zero vector.
    send(64'h0);
    wait_idle();

    // Full vector under random back-pressure.
    rand_ready = 1'b1;
    send(64'hFFFF_FFFF_FFFF_FFFF);
    wait_idle();
    rand_ready = 1'b0;
    @(posedge clk);
    #2;

    // Back-to-back vectors.
    send(64'h1);
    send(64'h2);
    wait_idle();

    // Flush after the second beat.
    send(64'hF0);
    wait_q_le(2);
    flush = 1'b1;
    q.delete();
    @(posedge clk);
    #2;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_valid", 128'(out_valid), 128'(0));
    chk("flush_ready", 128'(req_ready), 128'(1));
    repeat (3) @(posedge clk);
    #2;

    // Reset mid-iteration.
    send(64'hF0);
    wait_q_le(2);
    rst = 1'b1;
    q.delete();
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk("rst2_valid", 128'(out_valid), 128'(0));
    chk("rst2_ready", 128'(req_ready), 128'(1));
`ifdef PRIENC_MATCH_COUNT_EN
    chk("rst2_cnt", 128'(match_cnt), 128'(0));
`endif
    @(posedge clk);
    #2;

    // Random vectors with random back-pressure, sometimes back-to-back.
    rand_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 4))
        0: v = {$urandom, $urandom};
        1: v = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
        2: begin
          v = '0;
          v[$urandom_range(0, 63)] = 1'b1;
        end
        3: v = '0;
        default: v = {$urandom, $urandom} | {$urandom, $urandom};
      endcase
      send(v);
      if ($urandom_range(0, 2) == 0) wait_idle();
    end
    wait_idle();
    rand_ready = 1'b0;

    // 128-bit instance: single hits including the top bit, then a pair.
    for (int k = 0; k < 6; k++) begin
      bitpos = (k == 0) ? 127 : int'($urandom_range(0, 127));
      w = '0;
      w[bitpos] = 1'b1;
      req_vec2   = w;
      req_valid2 = 1'b1;
      @(negedge clk);
      chk("w128_ready", 128'(req_ready2), 128'(1));
      @(posedge clk);
      #2;
      req_valid2 = 1'b0;
      @(negedge clk);
      chk("w128_valid", 128'(out_valid2), 128'(1));
      chk("w128_idx", 128'(out_idx2), 128'(bitpos));
      chk("w128_last", 128'(out_last2), 128'(1));
      chk("w128_none", 128'(out_none2), 128'(0));
`ifdef PRIENC_MATCH_COUNT_EN
      chk("w128_cnt", 128'(match_cnt2), 128'(1));
`endif
      @(posedge clk);
      #2;
      @(negedge clk);
      chk("w128_idle", 128'(out_valid2), 128'(0));
      @(posedge clk);
      #2;
    end
    w = '0;
    w[17]  = 1'b1;
    w[100] = 1'b1;
    req_vec2   = w;
    req_valid2 = 1'b1;
    @(posedge clk);
    #2;
    req_valid2 = 1'b0;
    @(negedge clk);
    chk("w128_pair_idx0", 128'(out_idx2), 128'(17));
    chk("w128_pair_last0", 128'(out_last2), 128'(0));
    @(posedge clk);
    #2;
    @(negedge clk);
    chk("w128_pair_idx1", 128'(out_idx2), 128'(100));
    chk("w128_pair_last1", 128'(out_last2), 128'(1));
    @(posedge clk);
    #2;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
